config_payload_loader: RTL
==========================

# config_payload_loader

Downstream stage of the JTAG configuration header decoder. Once the 16-bit header (4-bit type, 12-bit length) has been decoded, this block deserialises the following `length` payload words from `tdi`, presents each word with an address and the header type over a valid/ready interface to the configuration fabric/key store, and signals completion or error. It sits between the header decoder and the configuration write port, all on the JTAG shift clock.

## Interface
- `WORD_W`, 16: payload word width in bits.
- `LEN_W`, 12: header length field width; also the word-address width.
- `clk`  in  1: JTAG shift clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `tdi`  in  1: serial payload bit, MSB of each word first.
- `en`  in  1: shift enable; `tdi` is sampled only when high.
- `hdr_valid`  in  1: one-cycle pulse; the header fields are valid.
- `hdr_type`  in  4: header type field.
- `hdr_length`  in  LEN_W: number of payload words.
- `word_data`  out  WORD_W: assembled payload word.
- `word_addr`  out  LEN_W: word index within the frame, starting at 0.
- `word_type`  out  4: latched `hdr_type`.
- `word_valid`  out  1: `word_data`/`word_addr`/`word_type` valid.
- `word_ready`  in  1: consumer accepts the word.
- `busy`  out  1: a frame is in progress (LOAD or DRAIN).
- `done`  out  1: one-cycle pulse at frame completion.
- `err`  out  1: sticky error; cleared only by `rst`.

## Operation
- States: IDLE, LOAD, DRAIN, DONE, ERR.
- IDLE: on `hdr_valid`:
  - Legal type (1 = fabric config, 2 = key, 3 = readback-mask):
    - `hdr_length != 0` -> LOAD; latch type and length; clear the bit counter, word counter and shift register.
    - `hdr_length == 0` -> DONE.
  - Any other type -> ERR.
- `hdr_valid` outside IDLE is ignored.
- LOAD:
  - Each `clk` with `en=1`: `sr <= {sr[WORD_W-2:0], tdi}` and the bit counter increments.
  - `en=0` pauses the shift; the partial word and counters are held.
  - On the WORD_W-th bit, `{sr[WORD_W-2:0], tdi}` loads the holding register: `word_valid` rises, `word_addr` takes the word counter, the word counter increments, and the bit counter wraps to 0.
  - Shifting continues while the holding register awaits `word_ready` (one word of buffering).
- Overrun: a word completes while `word_valid=1` and `word_ready=0` in that same cycle -> ERR; that word is discarded.
- Completion: when a completing word is the `length`-th word -> DRAIN.
- DRAIN:
  - `tdi`/`en` are ignored.
  - On `word_valid & word_ready` -> DONE.
- DONE: `done=1` for one cycle, then IDLE.
- ERR:
  - `err=1`, `word_valid=0`, `busy=0`.
  - Held until `rst`; all inputs are ignored.
- Handshake: a transfer occurs when `word_valid & word_ready` on a rising edge. `word_data`, `word_addr` and `word_type` are stable while `word_valid=1 & word_ready=0`. `word_valid` never drops without a transfer, except on entry to ERR or on `rst`.
- A transfer and a new word completion in the same cycle is legal: the holding register reloads and `word_valid` stays 1.
- Arithmetic: counters are unsigned. The word counter is LEN_W bits wide and never wraps, because the frame ends at `length` words. The bit counter is `$clog2(WORD_W)` bits.

## Timing
- Reset values: IDLE; `word_data=0`, `word_addr=0`, `word_type=0`, `word_valid=0`, `busy=0`, `done=0`, `err=0`; counters and shift register 0.
- `rst` mid-frame: next cycle matches the reset values; any partial word is lost.
- `hdr_valid` at edge N -> `busy=1` after edge N (LOAD); the first payload bit may be sampled at edge N+1.
- Last bit of a word sampled at edge M -> `word_valid=1` after edge M.
- Minimum frame time: `length*WORD_W` enabled cycles + 1 DRAIN handshake cycle (or more under backpressure) + 1 DONE cycle.
- Zero-length frame: `hdr_valid` at edge N -> `done=1` after edge N+1.
- `busy` is 1 exactly in LOAD and DRAIN.

## Structure
- Shared package `config_pkg`:
  - State enum.
  - Type codes `CFG_TYPE_FABRIC=4'h1`, `CFG_TYPE_KEY=4'h2`, `CFG_TYPE_RBMASK=4'h3`.
  - Defaults for `WORD_W` and `LEN_W`, shared with the header decoder.
- One sub-module, `word_deserializer`: shift register plus bit counter, with a `word_done` strobe output. The FSM, word counter and holding register remain in `config_payload_loader`.

## Test plan
- Type 1, length 2, `en` continuously high, bits 0xA5C3 then 0x1234, `word_ready=1` -> words (0xA5C3, addr 0, type 1) and (0x1234, addr 1, type 1); `done` pulses once; `err=0`.
- Type 2, length 0 -> no `word_valid`; `done=1` two cycles after `hdr_valid`; `busy` never asserts.
- `hdr_type=4'hF`, length 5 -> `err=1` next cycle and held for 100 cycles; `hdr_valid`/`tdi` ignored; `rst` clears it.
- Type 1, length 3, `word_ready=0` until the second word completes -> `err=1` at that edge; the first word (addr 0) stays held until entry to ERR; no `done`.
- Type 3, length 1, `en` low for 7 cycles after bit 5 of 0xBEEF -> single word 0xBEEF, addr 0; `word_ready` held low 4 cycles in DRAIN -> data stable; `done` follows the transfer.
- `rst` pulsed after 10 bits of word 1 in a length-4 frame -> all outputs at reset values; a new frame of length 1 with 0x0F0F completes correctly with addr 0.

Source files
------------

// File: rtl/config_pkg.sv
// Shared definitions for the JTAG configuration header decoder and payload loader.
package config_pkg;

  localparam int unsigned CFG_WORD_W = 16;
  localparam int unsigned CFG_LEN_W  = 12;

  localparam logic [3:0] CFG_TYPE_FABRIC = 4'h1;
  localparam logic [3:0] CFG_TYPE_KEY    = 4'h2;
  localparam logic [3:0] CFG_TYPE_RBMASK = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic type_is_legal(input logic [3:0] t);
    return (t == CFG_TYPE_FABRIC) || (t == CFG_TYPE_KEY) || (t == CFG_TYPE_RBMASK);
  endfunction

endpackage

// File: rtl/word_deserializer.sv
// Serial-to-parallel word assembler, MSB first, with a strobe on the last bit.
module word_deserializer
  import config_pkg::*;
#(
  parameter int unsigned WORD_W = CFG_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic              tdi,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int unsigned     BC_W     = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  // Only WORD_W-1 bits are stored; the final bit comes straight from tdi so the
  // completed word is available in the same cycle its last bit is sampled.
  logic [WORD_W-2:0] sr;
  logic [BC_W-1:0]   bit_cnt;

  assign word      = {sr, tdi};
  assign word_done = shift && (bit_cnt == LAST_BIT);

  // Shift register and bit counter; held while shift is low.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= word[WORD_W-2:0];
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BC_W'(1);
    end
  end

endmodule

// File: rtl/config_payload_loader.sv
// Payload loader: deserialises `length` words after a decoded header and hands
// each word to the configuration write port over valid/ready.
module config_payload_loader
  import config_pkg::*;
#(
  parameter int unsigned WORD_W = CFG_WORD_W,
  parameter int unsigned LEN_W  = CFG_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tdi,
  input  logic              en,
  input  logic              hdr_valid,
  input  logic [3:0]        hdr_type,
  input  logic [LEN_W-1:0]  hdr_length,
  output logic [WORD_W-1:0] word_data,
  output logic [LEN_W-1:0]  word_addr,
  output logic [3:0]        word_type,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_next;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wcnt;
  logic [WORD_W-1:0] word;
  logic              word_done;
  logic              shift, xfer, overrun, last_word, start;

  assign shift     = (state == ST_LOAD) && en;
  assign xfer      = word_valid && word_ready;
  assign overrun   = word_done && word_valid && !word_ready;
  assign last_word = (wcnt + LEN_W'(1)) == len_q;
  assign start     = (state == ST_IDLE) && hdr_valid && type_is_legal(hdr_type)
                     && (hdr_length != '0);

  assign busy = (state == ST_LOAD) || (state == ST_DRAIN);
  assign err  = (state == ST_ERR);

  // Counters are held clear outside LOAD, which also clears them on frame start.
  word_deserializer #(
    .WORD_W (WORD_W)
  ) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clr       (state != ST_LOAD),
    .shift     (shift),
    .tdi       (tdi),
    .word      (word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (hdr_valid) begin
          if (!type_is_legal(hdr_type))  state_next = ST_ERR;
          else if (hdr_length == '0)     state_next = ST_DONE;
          else                           state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (overrun)                     state_next = ST_ERR;
        else if (word_done && last_word) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (xfer)                state_next = ST_DONE;
      ST_DONE:                           state_next = ST_IDLE;
      ST_ERR:                            state_next = ST_ERR;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // Holding register, word counter and latched header fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_data  <= '0;
      word_addr  <= '0;
      word_type  <= '0;
      word_valid <= 1'b0;
      len_q      <= '0;
      wcnt       <= '0;
    end else if (state_next == ST_ERR) begin
      word_valid <= 1'b0;
    end else begin
      if (start) begin
        word_type <= hdr_type;
        len_q     <= hdr_length;
        wcnt      <= '0;
      end
      // A completion takes priority over a transfer so a same-cycle
      // transfer-and-reload keeps word_valid high.
      if (word_done) begin
        word_data  <= word;
        word_addr  <= wcnt;
        wcnt       <= wcnt + LEN_W'(1);
        word_valid <= 1'b1;
      end else if (xfer) begin
        word_valid <= 1'b0;
      end
    end
  end

  // Completion pulse, registered one cycle after the DONE state.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= (state == ST_DONE);
  end

endmodule
